// File: rtl/i2c_bus_rx_pkg.sv
// I2C receive front end shared definitions: FSM encodings, byte geometry, shift helper.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package i2c_bus_rx_pkg;

    // FSM encodings shared with the I2C slave FSM
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam int BITS_PER_BYTE = 8;
    localparam int BITCNT_W      = 3;

    // Bit counter value at which the byte is complete
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(BITS_PER_BYTE - 1);

    // MSB-first deserialisation: the newest bus bit enters at the LSB
    function automatic logic [BITS_PER_BYTE-1:0] shift_in(
        input logic [BITS_PER_BYTE-1:0] sh,
        input logic                     b
    );
        return {sh[BITS_PER_BYTE-2:0], b};
    endfunction

endpackage

// File: rtl/i2c_bus_rx_sync.sv
// Multi-flop synchroniser for one deglitched I2C line, resetting to the idle (high) level.
// Latency: SYNC_STAGES clk_i cycles from d_i to q_o.
// Backpressure: none; free-running.
module i2c_bus_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift chain; reset to 1 so a released reset never looks like an SDA/SCL fall
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_bus_rx.sv
// I2C receive front end: START/RSTART/STOP detect, MSB-first byte deserialise, ACK sample, SCL-low timeout.
// Latency: pin to edge detect SYNC_STAGES+1 cycles; byte valid one cycle after the 8th SCL rise is seen.
// Backpressure: byte_vld_o held until byte_rdy_i; a byte completing while one is still held is dropped and sets ovf_o.
module i2c_bus_rx
    import i2c_bus_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       start_det_o,
    output logic       rstart_o,
    output logic       stop_det_o,
    output logic       bus_busy_o,
    output logic [7:0] byte_data_o,
    output logic       byte_vld_o,
    input  logic       byte_rdy_i,
    output logic       ack_slot_o,
    output logic       ack_bit_o,
    output logic       ovf_o,
    output logic       timeout_o
);

    localparam logic [TIMEOUT_W-1:0] TMO_MAX  = {TIMEOUT_W{1'b1}};
    // Hit is flagged on the cycle that would take the counter to TMO_MAX
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic scl_s, sda_s;
    logic scl_q, sda_q;

    logic [1:0]               state_q,     state_d;
    logic [BITCNT_W-1:0]      bitcnt_q,    bitcnt_d;
    logic [BITS_PER_BYTE-1:0] shreg_q,     shreg_d;
    logic                     busy_q,      busy_d;
    logic [7:0]               byte_data_q, byte_data_d;
    logic                     byte_vld_q,  byte_vld_d;
    logic                     ack_bit_q,   ack_bit_d;
    logic                     ovf_q,       ovf_d;
    logic [TIMEOUT_W-1:0]     tcnt_q,      tcnt_d;
    logic                     start_q,     start_d;
    logic                     rstart_q,    rstart_d;
    logic                     stop_q,      stop_d;
    logic                     ack_slot_q,  ack_slot_d;
    logic                     timeout_q,   timeout_d;

    logic                     scl_rise;
    logic                     cond_ok;
    logic                     start_c;
    logic                     stop_c;
    logic                     tmo_hit;
    logic                     byte_done;
    logic [BITS_PER_BYTE-1:0] new_byte;

    i2c_bus_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (scl_i),
        .q_o    (scl_s)
    );

    i2c_bus_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (sda_i),
        .q_o    (sda_s)
    );

    // Previous synced line levels for edge detection; idle bus is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_s;
            sda_q <= sda_s;
        end
    end

    // SDA conditions only count when SCL was high and stayed high, so a
    // simultaneous SCL/SDA change never produces START or STOP
    assign scl_rise = scl_s & ~scl_q;
    assign cond_ok  = scl_s & scl_q;
    assign start_c  = cond_ok & sda_q & ~sda_s;
    assign stop_c   = cond_ok & ~sda_q & sda_s;
    assign tmo_hit  = busy_q & ~scl_s & (tcnt_q == TMO_LAST);
    assign new_byte = shift_in(shreg_q, sda_s);

    // Next-state: bus conditions, bit/ACK sampling, timeout and output handshake
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        busy_d      = busy_q;
        byte_data_d = byte_data_q;
        byte_vld_d  = byte_vld_q;
        ack_bit_d   = ack_bit_q;
        ovf_d       = ovf_q;
        tcnt_d      = tcnt_q;
        start_d     = 1'b0;
        rstart_d    = 1'b0;
        stop_d      = 1'b0;
        ack_slot_d  = 1'b0;
        timeout_d   = 1'b0;
        byte_done   = 1'b0;

        if (!en_i) begin
            // Disabled: park in IDLE; resume only at the next START after enable
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            bitcnt_d = '0;
            tcnt_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (!busy_q || scl_s) begin
                tcnt_d = '0;
            end else if (tcnt_q != TMO_MAX) begin
                tcnt_d = tcnt_q + 1'b1;
            end

            if (tmo_hit) begin
                timeout_d = 1'b1;
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                bitcnt_d  = '0;
            end else if (stop_c) begin
                stop_d   = 1'b1;
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                bitcnt_d = '0;
            end else if (start_c) begin
                start_d  = 1'b1;
                rstart_d = busy_q;
                state_d  = ST_DATA;
                busy_d   = 1'b1;
                bitcnt_d = '0;
            end else if (scl_rise) begin
                case (state_q)
                    ST_DATA: begin
                        shreg_d = new_byte;
                        if (bitcnt_q == LAST_BIT) begin
                            byte_done = 1'b1;
                            bitcnt_d  = '0;
                            state_d   = ST_ACK;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                    ST_ACK: begin
                        ack_bit_d  = sda_s;
                        ack_slot_d = 1'b1;
                        bitcnt_d   = '0;
                        state_d    = ST_DATA;
                    end
                    default: begin
                    end
                endcase
            end
        end

        // Held byte wins over a new one unless it is being accepted this cycle
        if (byte_done) begin
            if (byte_vld_q && !byte_rdy_i) begin
                ovf_d = 1'b1;
            end else begin
                byte_data_d = new_byte;
                byte_vld_d  = 1'b1;
            end
        end else if (byte_vld_q && byte_rdy_i) begin
            byte_vld_d = 1'b0;
        end
    end

    // State, datapath and registered output update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            busy_q      <= 1'b0;
            byte_data_q <= '0;
            byte_vld_q  <= 1'b0;
            ack_bit_q   <= 1'b0;
            ovf_q       <= 1'b0;
            tcnt_q      <= '0;
            start_q     <= 1'b0;
            rstart_q    <= 1'b0;
            stop_q      <= 1'b0;
            ack_slot_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            busy_q      <= busy_d;
            byte_data_q <= byte_data_d;
            byte_vld_q  <= byte_vld_d;
            ack_bit_q   <= ack_bit_d;
            ovf_q       <= ovf_d;
            tcnt_q      <= tcnt_d;
            start_q     <= start_d;
            rstart_q    <= rstart_d;
            stop_q      <= stop_d;
            ack_slot_q  <= ack_slot_d;
            timeout_q   <= timeout_d;
        end
    end

    assign start_det_o = start_q;
    assign rstart_o    = rstart_q;
    assign stop_det_o  = stop_q;
    assign bus_busy_o  = busy_q;
    assign byte_data_o = byte_data_q;
    assign byte_vld_o  = byte_vld_q;
    assign ack_slot_o  = ack_slot_q;
    assign ack_bit_o   = ack_bit_q;
    assign ovf_o       = ovf_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_i2c_bus_rx.sv
// Bench for i2c_bus_rx: bus-level driver with a transaction-level reference model.
module tb_i2c_bus_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       scl;
    logic       sda;
    logic       byte_rdy;
    logic       start_det, rstart, stop_det, bus_busy;
    logic [7:0] byte_data;
    logic       byte_vld, ack_slot, ack_bit, ovf, timeout;

    i2c_bus_rx #(.SYNC_STAGES(2), .TIMEOUT_W(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .scl_i       (scl),
        .sda_i       (sda),
        .start_det_o (start_det),
        .rstart_o    (rstart),
        .stop_det_o  (stop_det),
        .bus_busy_o  (bus_busy),
        .byte_data_o (byte_data),
        .byte_vld_o  (byte_vld),
        .byte_rdy_i  (byte_rdy),
        .ack_slot_o  (ack_slot),
        .ack_bit_o   (ack_bit),
        .ovf_o       (ovf),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // observed activity
    int         n_start = 0, n_rstart = 0, n_stop = 0, n_tmo = 0, n_vld_cyc = 0;
    logic [7:0] got_bytes[$];
    logic       got_acks[$];

    // reference model state
    int         e_start = 0, e_rstart = 0, e_stop = 0, e_tmo = 0;
    logic [7:0] exp_bytes[$];
    logic       exp_acks[$];
    logic       m_busy = 1'b0, m_ack = 1'b0, m_pend = 1'b0, m_ovf = 1'b0;
    int         m_bits = 0;
    logic [7:0] m_sh = 8'h00, m_held = 8'h00;

    // monitor samples at the falling edge, away from the active edge
    always @(negedge clk) begin
        if (start_det) n_start++;
        if (rstart)    n_rstart++;
        if (stop_det)  n_stop++;
        if (timeout)   n_tmo++;
        if (byte_vld)  n_vld_cyc++;
        if (ack_slot)  got_acks.push_back(ack_bit);
        if (byte_vld && byte_rdy) got_bytes.push_back(byte_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---- reference model: I2C rules at the bus-event level ----
    task automatic m_complete(input logic [7:0] v);
        if (byte_rdy) exp_bytes.push_back(v);
        else if (m_pend) m_ovf = 1'b1;
        else begin m_pend = 1'b1; m_held = v; end
    endtask

    task automatic m_rise(input logic b);
        if (!m_busy) return;
        if (!m_ack) begin
            m_sh = {m_sh[6:0], b};
            m_bits++;
            if (m_bits == 8) begin
                m_bits = 0;
                m_ack  = 1'b1;
                m_complete(m_sh);
            end
        end else begin
            exp_acks.push_back(b);
            m_ack = 1'b0;
        end
    endtask

    task automatic m_start();
        if (m_busy) e_rstart++;
        e_start++;
        m_busy = 1'b1; m_ack = 1'b0; m_bits = 0;
    endtask

    // ---- bus driver ----
    task automatic bus_start();
        sda = 1'b1; tick(2);
        if (!scl) begin scl = 1'b1; m_rise(1'b1); end
        tick(4);
        sda = 1'b0; m_start(); tick(4);
        scl = 1'b0; tick(2);
    endtask

    task automatic bus_bit(input logic b);
        sda = b; tick(2);
        scl = 1'b1; m_rise(b); tick(4);
        scl = 1'b0; tick(2);
    endtask

    task automatic bus_stop();
        sda = 1'b0; tick(2);
        scl = 1'b1; m_rise(1'b0); tick(4);
        sda = 1'b1; e_stop++; m_busy = 1'b0; tick(4);
    endtask

    task automatic bus_idle();
        sda = 1'b1; tick(2);
        scl = 1'b1; m_rise(1'b1); tick(4);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic a);
        for (int i = 7; i >= 0; i--) bus_bit(v[i]);
        bus_bit(a);
    endtask

    task automatic check_all(input string tag);
        tick(6);
        chk({tag, "_n_start"},  n_start,  e_start);
        chk({tag, "_n_rstart"}, n_rstart, e_rstart);
        chk({tag, "_n_stop"},   n_stop,   e_stop);
        chk({tag, "_n_tmo"},    n_tmo,    e_tmo);
        chk({tag, "_busy"},     {31'd0, bus_busy}, {31'd0, m_busy});
        chk({tag, "_nbytes"},   got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            chk({tag, "_byte"}, {24'd0, got_bytes[i]}, {24'd0, exp_bytes[i]});
        chk({tag, "_nacks"},    got_acks.size(), exp_acks.size());
        for (int i = 0; i < exp_acks.size() && i < got_acks.size(); i++)
            chk({tag, "_ack"}, {31'd0, got_acks[i]}, {31'd0, exp_acks[i]});
        got_bytes.delete(); exp_bytes.delete();
        got_acks.delete();  exp_acks.delete();
    endtask

    function automatic logic [16:0] all_outs();
        return {start_det, rstart, stop_det, bus_busy, ack_slot, ack_bit,
                ovf, timeout, byte_vld, byte_data};
    endfunction

    initial begin
        int nb;
        int k;
        int nbytes_tot;
        logic [7:0] v;

        // 1: reset and quiet idle bus
        rst_n = 1'b0; en = 1'b1; byte_rdy = 1'b1; scl = 1'b1; sda = 1'b1;
        tick(3);
        chk("reset_outs", {15'd0, all_outs()}, 32'd0);
        rst_n = 1'b1;
        tick(20);
        chk("idle_outs", {15'd0, all_outs()}, 32'd0);
        chk("idle_start", n_start, 0);
        chk("idle_stop", n_stop, 0);

        // 2: single byte 0xA5 with ACK
        n_vld_cyc = 0;
        bus_start();
        chk("t2_busy_hi", {31'd0, bus_busy}, 32'd1);
        send_byte(8'hA5, 1'b0);
        bus_stop();
        check_all("t2");
        chk("t2_vld_cycles", n_vld_cyc, 1);

        // random transactions, consumer always ready
        n_vld_cyc = 0;
        nbytes_tot = 0;
        repeat (4) begin
            bus_start();
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) begin
                v = 8'($urandom);
                send_byte(v, 1'($urandom_range(0, 1)));
            end
            nbytes_tot += nb;
            bus_stop();
        end
        check_all("rnd");
        chk("rnd_vld_cycles", n_vld_cyc, nbytes_tot);

        // 3: overflow with consumer stalled
        byte_rdy = 1'b0;
        bus_start();
        send_byte(8'h3C, 1'b0);
        send_byte(8'hF0, 1'b1);
        bus_stop();
        tick(6);
        chk("t3_data_held", {24'd0, byte_data}, {24'd0, m_held});
        chk("t3_vld", {31'd0, byte_vld}, 32'd1);
        chk("t3_ovf", {31'd0, ovf}, {31'd0, m_ovf});
        byte_rdy = 1'b1;
        exp_bytes.push_back(m_held); m_pend = 1'b0;
        tick(3);
        chk("t3_vld_drop", {31'd0, byte_vld}, 32'd0);
        chk("t3_ovf_sticky", {31'd0, ovf}, 32'd1);
        en = 1'b0; m_ovf = 1'b0;
        tick(2);
        chk("t3_ovf_clr", {31'd0, ovf}, {31'd0, m_ovf});
        en = 1'b1;
        check_all("t3");

        // 4: partial byte abandoned by repeated START
        bus_start();
        k = $urandom_range(1, 6);
        repeat (k) bus_bit(1'($urandom_range(0, 1)));
        bus_start();
        send_byte(8'h81, 1'b0);
        bus_stop();
        check_all("t4");

        // 5: SCL held low past the timeout
        bus_start();
        tick(20);
        e_tmo++; m_busy = 1'b0;
        chk("t5_tmo", n_tmo, e_tmo);
        chk("t5_busy", {31'd0, bus_busy}, 32'd0);
        bus_idle();
        scl = 1'b0; tick(2);
        v = 8'($urandom);
        send_byte(v, 1'b0);
        bus_idle();
        check_all("t5");

        // 6: simultaneous SCL/SDA changes give no condition
        scl = 1'b0; sda = 1'b0; tick(4);
        scl = 1'b1; sda = 1'b1; m_rise(1'b1); tick(4);
        check_all("t6_sim");

        // 6: reset mid-byte with a byte pending
        byte_rdy = 1'b0;
        bus_start();
        v = 8'($urandom);
        send_byte(v, 1'b1);
        tick(2);
        chk("t6_pend_vld", {31'd0, byte_vld}, 32'd1);
        chk("t6_pend_data", {24'd0, byte_data}, {24'd0, m_held});
        repeat (4) bus_bit(1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", {15'd0, all_outs()}, 32'd0);
        m_busy = 1'b0; m_ack = 1'b0; m_bits = 0; m_pend = 1'b0; m_ovf = 1'b0;
        sda = 1'b1; tick(2);
        scl = 1'b1; tick(2);
        rst_n = 1'b1; byte_rdy = 1'b1;
        tick(4);
        bus_start();
        v = 8'($urandom);
        send_byte(v, 1'b0);
        bus_stop();
        check_all("t6_after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
